// File: rtl/physics_pkg.sv
`default_nettype none
// ============================================================================
// physics_pkg : shared state encoding and saturating arithmetic helpers
// Rev 1.0
// ============================================================================
package physics_pkg;

    localparam int ACC_EXTRA = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCUM     = 2'd1,
        ST_INTEGRATE = 2'd2,
        ST_DONE      = 2'd3
    } integ_state_t;

    // Clamp x to the signed range of a w-bit value (w <= 32).
    function automatic logic signed [31:0] sat_clamp(input longint x, input int w);
        longint hi;
        longint lo;
        longint r;
        hi = (longint'(1) <<< (w - 1)) - longint'(1);
        lo = -hi - longint'(1);
        r  = x;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return 32'(r);
    endfunction

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        return sat_clamp(longint'(a) + longint'(b), w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/euler_step.sv
`default_nettype none
// ============================================================================
// euler_step : one-axis explicit-Euler update, v' = v + f*dt, p' = p + v'*dt
// Rev 1.0
// ============================================================================
module euler_step
    import physics_pkg::*;
#(
    parameter int FORCE_W       = 12,
    parameter int VELOCITY_SIZE = 8,
    parameter int POSITION_SIZE = 8,
    parameter int DT_SHIFT      = 2
) (
    input  logic signed [FORCE_W-1:0]       force_i,
    input  logic signed [VELOCITY_SIZE-1:0] vel_i,
    input  logic signed [POSITION_SIZE-1:0] pos_i,
    output logic signed [VELOCITY_SIZE-1:0] vel_o,
    output logic signed [POSITION_SIZE-1:0] pos_o
);

    logic signed [FORCE_W-1:0]       w_dv;
    logic signed [VELOCITY_SIZE-1:0] w_v;
    logic signed [VELOCITY_SIZE-1:0] w_dp;

    // Position uses the already-updated velocity (semi-implicit ordering).
    always_comb begin
        w_dv  = force_i >>> DT_SHIFT;
        w_v   = VELOCITY_SIZE'(sat_add(32'(w_dv), 32'(vel_i), VELOCITY_SIZE));
        w_dp  = w_v >>> DT_SHIFT;
        vel_o = w_v;
        pos_o = POSITION_SIZE'(sat_add(32'(w_dp), 32'(pos_i), POSITION_SIZE));
    end

endmodule
`default_nettype wire

// File: rtl/node_integrator.sv
`default_nettype none
// ============================================================================
// node_integrator : per-frame force accumulation and node/axle Euler stepping
// Rev 1.0
// ============================================================================
module node_integrator
    import physics_pkg::*;
#(
    parameter int NUM_NODES     = 10,
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 8,
    parameter int FORCE_SIZE    = 8,
    parameter int DT_SHIFT      = 2
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          force_in_valid,
    input  logic [FORCE_SIZE-1:0]                         force_x_in,
    input  logic [FORCE_SIZE-1:0]                         force_y_in,
    input  logic [FORCE_SIZE-1:0]                         axle_force_x,
    input  logic [FORCE_SIZE-1:0]                         axle_force_y,
    input  logic                                          forces_done,
    input  logic [FORCE_SIZE-1:0]                         gravity,
    input  logic                                          load_valid,
    input  logic [$clog2(NUM_NODES+1)-1:0]                load_index,
    input  logic [1:0][POSITION_SIZE-1:0]                 load_pos,
    input  logic [1:0][VELOCITY_SIZE-1:0]                 load_vel,
    output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes,
    output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  velocities,
    output logic [1:0][POSITION_SIZE-1:0]                 axle,
    output logic [1:0][VELOCITY_SIZE-1:0]                 axle_velocity,
    output logic                                          busy,
    output logic                                          output_valid,
    output logic                                          dropped_out
);

    localparam int ACC_W  = FORCE_SIZE + ACC_EXTRA;
    localparam int ENT_W  = $clog2(NUM_NODES + 1);
    localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_NODES - 1);
    localparam logic [ENT_W-1:0]  AXLE_ENT  = ENT_W'(NUM_NODES);

    integ_state_t state_q, state_d;

    logic [NODE_W-1:0]       idx_q;
    logic [ENT_W-1:0]        i_q;
    logic signed [ACC_W-1:0] acc_x_q [NUM_NODES];
    logic signed [ACC_W-1:0] acc_y_q [NUM_NODES];
    logic signed [ACC_W-1:0] axle_fx_q, axle_fy_q;

    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] pos_q;
    logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_q;
    logic [1:0][POSITION_SIZE-1:0]                axle_pos_q;
    logic [1:0][VELOCITY_SIZE-1:0]                axle_vel_q;
    logic busy_q, valid_q, dropped_q;

    logic                            w_is_axle;
    logic [NODE_W-1:0]               w_sel, w_load_sel;
    logic signed [ACC_W-1:0]         w_fx, w_fy_raw, w_fy, w_acc_x_nxt, w_acc_y_nxt;
    logic signed [VELOCITY_SIZE-1:0] w_vx_cur, w_vy_cur, w_vx_new, w_vy_new;
    logic signed [POSITION_SIZE-1:0] w_px_cur, w_py_cur, w_px_new, w_py_new;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (forces_done) begin
                    state_d = ST_INTEGRATE;
                end else if (force_in_valid) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_INTEGRATE: if (i_q == AXLE_ENT) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Entry mux: one node per cycle, then the axle with its captured force.
    always_comb begin
        w_is_axle   = (i_q == AXLE_ENT);
        w_sel       = w_is_axle ? '0 : NODE_W'(i_q);
        w_load_sel  = NODE_W'(load_index);
        w_fx        = w_is_axle ? axle_fx_q : acc_x_q[w_sel];
        w_fy_raw    = w_is_axle ? axle_fy_q : acc_y_q[w_sel];
        w_fy        = ACC_W'(sat_add(32'(w_fy_raw), 32'($signed(gravity)), ACC_W));
        w_vx_cur    = w_is_axle ? axle_vel_q[0] : vel_q[0][w_sel];
        w_vy_cur    = w_is_axle ? axle_vel_q[1] : vel_q[1][w_sel];
        w_px_cur    = w_is_axle ? axle_pos_q[0] : pos_q[0][w_sel];
        w_py_cur    = w_is_axle ? axle_pos_q[1] : pos_q[1][w_sel];
        w_acc_x_nxt = ACC_W'(sat_add(32'(acc_x_q[idx_q]), 32'($signed(force_x_in)), ACC_W));
        w_acc_y_nxt = ACC_W'(sat_add(32'(acc_y_q[idx_q]), 32'($signed(force_y_in)), ACC_W));
    end

    euler_step #(
        .FORCE_W(ACC_W), .VELOCITY_SIZE(VELOCITY_SIZE),
        .POSITION_SIZE(POSITION_SIZE), .DT_SHIFT(DT_SHIFT)
    ) u_step_x (
        .force_i(w_fx), .vel_i(w_vx_cur), .pos_i(w_px_cur),
        .vel_o(w_vx_new), .pos_o(w_px_new)
    );

    euler_step #(
        .FORCE_W(ACC_W), .VELOCITY_SIZE(VELOCITY_SIZE),
        .POSITION_SIZE(POSITION_SIZE), .DT_SHIFT(DT_SHIFT)
    ) u_step_y (
        .force_i(w_fy), .vel_i(w_vy_cur), .pos_i(w_py_cur),
        .vel_o(w_vy_new), .pos_o(w_py_new)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_q      <= '0;
            i_q        <= '0;
            axle_fx_q  <= '0;
            axle_fy_q  <= '0;
            pos_q      <= '0;
            vel_q      <= '0;
            axle_pos_q <= '0;
            axle_vel_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            dropped_q  <= 1'b0;
            for (int n = 0; n < NUM_NODES; n++) begin
                acc_x_q[n] <= '0;
                acc_y_q[n] <= '0;
            end
        end else begin
            busy_q  <= (state_d == ST_ACCUM) || (state_d == ST_INTEGRATE);
            valid_q <= (state_d == ST_DONE);
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (state_q == ST_IDLE && load_valid) begin
                        if (load_index == AXLE_ENT) begin
                            axle_pos_q <= load_pos;
                            axle_vel_q <= load_vel;
                        end else if (load_index < AXLE_ENT) begin
                            for (int a = 0; a < 2; a++) begin
                                pos_q[a][w_load_sel] <= load_pos[a];
                                vel_q[a][w_load_sel] <= load_vel[a];
                            end
                        end
                    end
                    // A force coincident with forces_done still lands before the step.
                    if (force_in_valid) begin
                        acc_x_q[idx_q] <= w_acc_x_nxt;
                        acc_y_q[idx_q] <= w_acc_y_nxt;
                        idx_q          <= (idx_q == LAST_NODE) ? '0 : idx_q + NODE_W'(1);
                    end
                    if (forces_done) begin
                        axle_fx_q <= ACC_W'($signed(axle_force_x));
                        axle_fy_q <= ACC_W'($signed(axle_force_y));
                        i_q       <= '0;
                    end
                end
                ST_INTEGRATE: begin
                    if (w_is_axle) begin
                        axle_pos_q <= {w_py_new, w_px_new};
                        axle_vel_q <= {w_vy_new, w_vx_new};
                    end else begin
                        pos_q[0][w_sel] <= w_px_new;
                        pos_q[1][w_sel] <= w_py_new;
                        vel_q[0][w_sel] <= w_vx_new;
                        vel_q[1][w_sel] <= w_vy_new;
                    end
                    i_q <= i_q + ENT_W'(1);
                    if (force_in_valid) dropped_q <= 1'b1;
                end
                ST_DONE: begin
                    idx_q <= '0;
                    for (int n = 0; n < NUM_NODES; n++) begin
                        acc_x_q[n] <= '0;
                        acc_y_q[n] <= '0;
                    end
                    if (force_in_valid) dropped_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign nodes         = pos_q;
    assign velocities    = vel_q;
    assign axle          = axle_pos_q;
    assign axle_velocity = axle_vel_q;
    assign busy          = busy_q;
    assign output_valid  = valid_q;
    assign dropped_out   = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_node_integrator.sv
`default_nettype none
// ============================================================================
// tb_node_integrator : directed + randomized frames against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_node_integrator;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int VW = 8;
    localparam int FW = 8;
    localparam int DS = 2;
    localparam int AW = FW + 4;
    localparam int LW = $clog2(N + 1);
    localparam int NW = $clog2(N);

    logic                         clk_in = 1'b0;
    logic                         rst_in;
    logic                         force_in_valid;
    logic [FW-1:0]                force_x_in, force_y_in;
    logic [FW-1:0]                axle_force_x, axle_force_y;
    logic                         forces_done;
    logic [FW-1:0]                gravity;
    logic                         load_valid;
    logic [LW-1:0]                load_index;
    logic [1:0][PW-1:0]           load_pos;
    logic [1:0][VW-1:0]           load_vel;
    logic [1:0][N-1:0][PW-1:0]    nodes;
    logic [1:0][N-1:0][VW-1:0]    velocities;
    logic [1:0][PW-1:0]           axle;
    logic [1:0][VW-1:0]           axle_velocity;
    logic                         busy, output_valid, dropped_out;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: entry N is the axle.
    int mp   [2][N+1];
    int mv   [2][N+1];
    int macc [2][N];
    int midx;
    int mgrav;

    node_integrator #(
        .NUM_NODES(N), .POSITION_SIZE(PW), .VELOCITY_SIZE(VW),
        .FORCE_SIZE(FW), .DT_SHIFT(DS)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .force_in_valid(force_in_valid), .force_x_in(force_x_in), .force_y_in(force_y_in),
        .axle_force_x(axle_force_x), .axle_force_y(axle_force_y),
        .forces_done(forces_done), .gravity(gravity),
        .load_valid(load_valid), .load_index(load_index),
        .load_pos(load_pos), .load_vel(load_vel),
        .nodes(nodes), .velocities(velocities), .axle(axle), .axle_velocity(axle_velocity),
        .busy(busy), .output_valid(output_valid), .dropped_out(dropped_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sat(int x, int w);
        int hi;
        int lo;
        hi = (1 <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Division by 2^s rounding toward minus infinity.
    function automatic int fshr(int x, int s);
        int d;
        d = 1 <<< s;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic int dpos(int a, int e);
        logic signed [PW-1:0] t;
        if (e < N) t = nodes[a[0]][e[NW-1:0]];
        else       t = axle[a[0]];
        return int'(t);
    endfunction

    function automatic int dvel(int a, int e);
        logic signed [VW-1:0] t;
        if (e < N) t = velocities[a[0]][e[NW-1:0]];
        else       t = axle_velocity[a[0]];
        return int'(t);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic m_clear();
        for (int a = 0; a < 2; a++) begin
            for (int e = 0; e <= N; e++) begin
                mp[a][e] = 0;
                mv[a][e] = 0;
            end
            for (int e = 0; e < N; e++) macc[a][e] = 0;
        end
        midx = 0;
    endtask

    task automatic m_accum(input int fx, input int fy);
        macc[0][midx] = sat(macc[0][midx] + fx, AW);
        macc[1][midx] = sat(macc[1][midx] + fy, AW);
        midx = (midx + 1) % N;
    endtask

    task automatic m_step(input int ax, input int ay);
        int f[2];
        for (int e = 0; e <= N; e++) begin
            f[0] = (e < N) ? macc[0][e] : ax;
            f[1] = sat(((e < N) ? macc[1][e] : ay) + mgrav, AW);
            for (int a = 0; a < 2; a++) begin
                mv[a][e] = sat(mv[a][e] + fshr(f[a], DS), VW);
                mp[a][e] = sat(mp[a][e] + fshr(mv[a][e], DS), PW);
            end
        end
        for (int a = 0; a < 2; a++)
            for (int e = 0; e < N; e++) macc[a][e] = 0;
        midx = 0;
    endtask

    task automatic check_state(input string tag);
        for (int a = 0; a < 2; a++) begin
            for (int e = 0; e <= N; e++) begin
                check($sformatf("%s pos[%0d][%0d]", tag, a, e), dpos(a, e), mp[a][e]);
                check($sformatf("%s vel[%0d][%0d]", tag, a, e), dvel(a, e), mv[a][e]);
            end
        end
    endtask

    task automatic set_grav(input int g);
        gravity = FW'(g);
        mgrav   = g;
    endtask

    task automatic do_reset(input int cycles);
        rst_in = 1'b1;
        repeat (cycles) tick();
        rst_in = 1'b0;
        m_clear();
    endtask

    task automatic load_entry(input int e, input int px, input int py, input int vx, input int vy);
        load_valid  = 1'b1;
        load_index  = LW'(e);
        load_pos[0] = PW'(px);
        load_pos[1] = PW'(py);
        load_vel[0] = VW'(vx);
        load_vel[1] = VW'(vy);
        tick();
        load_valid = 1'b0;
        mp[0][e] = px; mp[1][e] = py; mv[0][e] = vx; mv[1][e] = vy;
        check($sformatf("load%0d px", e), dpos(0, e), px);
        check($sformatf("load%0d vy", e), dvel(1, e), vy);
    endtask

    task automatic send(input int fx, input int fy);
        force_in_valid = 1'b1;
        force_x_in     = FW'(fx);
        force_y_in     = FW'(fy);
        tick();
        force_in_valid = 1'b0;
        m_accum(fx, fy);
        check("busy in accum", int'(busy), 1);
    endtask

    // inject: 0 none, 1 force during INTEGRATE, 2 load during INTEGRATE
    task automatic finish_frame(input string tag, input bit with_f, input int fx, input int fy,
                                input int ax, input int ay, input int inject);
        int cnt;
        forces_done  = 1'b1;
        axle_force_x = FW'(ax);
        axle_force_y = FW'(ay);
        if (with_f) begin
            force_in_valid = 1'b1;
            force_x_in     = FW'(fx);
            force_y_in     = FW'(fy);
        end
        tick();
        forces_done    = 1'b0;
        force_in_valid = 1'b0;
        if (with_f) m_accum(fx, fy);
        check({tag, " busy"}, int'(busy), 1);
        if (inject == 1) begin
            force_in_valid = 1'b1;
            force_x_in     = FW'(33);
            force_y_in     = FW'(-21);
        end else if (inject == 2) begin
            load_valid  = 1'b1;
            load_index  = LW'(1);
            load_pos[0] = PW'(77);
            load_pos[1] = PW'(-77);
            load_vel[0] = VW'(55);
            load_vel[1] = VW'(-55);
        end
        cnt = 0;
        while (output_valid !== 1'b1 && cnt < 20) begin
            tick();
            force_in_valid = 1'b0;
            load_valid     = 1'b0;
            cnt++;
        end
        check({tag, " latency"}, cnt, N + 1);
        m_step(ax, ay);
        check_state(tag);
        tick();
        check({tag, " valid pulse width"}, int'(output_valid), 0);
        check({tag, " idle busy"}, int'(busy), 0);
    endtask

    initial begin
        int saw;
        rst_in = 1'b1; force_in_valid = 1'b0; forces_done = 1'b0; load_valid = 1'b0;
        force_x_in = '0; force_y_in = '0; axle_force_x = '0; axle_force_y = '0;
        gravity = '0; load_index = '0; load_pos = '0; load_vel = '0;
        mgrav = 0;

        do_reset(2);
        check_state("reset");
        check("reset output_valid", int'(output_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset dropped", int'(dropped_out), 0);
        set_grav(-4);

        load_entry(1, 10, 20, 0, 0);
        repeat (N) send(8, 0);
        finish_frame("single", 1'b0, 0, 0, 0, 0, 0);
        check("single n1 vx", dvel(0, 1), 2);
        check("single n1 vy", dvel(1, 1), -1);
        check("single n1 px", dpos(0, 1), 10);
        check("single n1 py", dpos(1, 1), 19);
        check("single n0 px", dpos(0, 0), 0);
        check("single n0 py", dpos(1, 0), -1);

        load_entry(0, 0, 0, 120, 0);
        send(127, 4);
        finish_frame("saturate", 1'b0, 0, 0, 0, 0, 0);
        check("sat n0 vx", dvel(0, 0), 127);
        check("sat n0 px", dpos(0, 0), 31);
        check("sat n0 vy", dvel(1, 0), 0);
        check("sat n0 py", dpos(1, 0), 0);

        load_entry(2, 0, 0, 0, 0);
        load_entry(3, 0, 0, 0, 0);
        send(0, 0);
        send(0, 0);
        finish_frame("samecycle", 1'b1, 40, 0, 0, 0, 0);
        check("same n2 vx", dvel(0, 2), 10);
        check("same n3 vx", dvel(0, 3), 0);

        check("dropped before", int'(dropped_out), 0);
        send(12, -12);
        finish_frame("drop", 1'b0, 0, 0, 9, -9, 1);
        check("dropped set", int'(dropped_out), 1);
        finish_frame("loadignored", 1'b0, 0, 0, -5, 5, 2);
        check("dropped sticky", int'(dropped_out), 1);

        for (int f = 0; f < 8; f++) begin
            set_grav(int'($urandom_range(0, 255)) - 128);
            repeat ($urandom_range(0, 3))
                load_entry(int'($urandom_range(0, N)),
                           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            repeat ($urandom_range(0, 10))
                send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            finish_frame($sformatf("rand%0d", f), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                         int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 0);
        end

        set_grav(-4);
        send(5, 5);
        saw = 0;
        forces_done = 1'b1;
        tick();
        forces_done = 1'b0;
        tick();
        if (output_valid === 1'b1) saw = 1;
        tick();
        if (output_valid === 1'b1) saw = 1;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        m_clear();
        for (int k = 0; k < 10; k++) begin
            if (output_valid === 1'b1) saw = 1;
            tick();
        end
        check("midreset no valid", saw, 0);
        check("midreset dropped", int'(dropped_out), 0);
        check("midreset busy", int'(busy), 0);
        check_state("midreset");

        load_entry(1, 10, 20, 0, 0);
        repeat (N) send(8, 0);
        finish_frame("replay", 1'b0, 0, 0, 0, 0, 0);
        check("replay n1 vy", dvel(1, 1), -1);
        check("replay n1 py", dpos(1, 1), 19);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/node_integrator.md
# node_integrator

Explicit-Euler integration stage that sits directly downstream of the ideal-shape force block. It accumulates the per-node force stream (`force_x_out`/`force_y_out` with `force_out_valid`) and the axle force that arrive during a physics frame, and holds the node and axle position/velocity register file. On frame end it steps every node and then the axle once, and republishes the updated arrays to the force stages for the next frame.

## Interface
- `NUM_NODES`, 10: soft-body node count.
- `POSITION_SIZE`, 8: signed position width.
- `VELOCITY_SIZE`, 8: signed velocity width.
- `FORCE_SIZE`, 8: signed input force width.
- `DT_SHIFT`, 2: timestep as an arithmetic right shift.
- `clk_in` in 1: single clock, all logic posedge.
- `rst_in` in 1: synchronous, active-high reset.
- `force_in_valid` in 1: one node force per pulse, node order 0..NUM_NODES-1.
- `force_x_in`, `force_y_in` in FORCE_SIZE: signed node force.
- `axle_force_x`, `axle_force_y` in FORCE_SIZE: signed; sampled when `forces_done` is high.
- `forces_done` in 1: upstream `output_valid`; ends the frame.
- `gravity` in FORCE_SIZE: signed; added to every y force.
- `load_valid` in 1: write one state entry; honoured only in IDLE.
- `load_index` in $clog2(NUM_NODES+1): 0..NUM_NODES-1 selects a node; NUM_NODES selects the axle.
- `load_pos` in [1:0][POSITION_SIZE]: position to write.
- `load_vel` in [1:0][VELOCITY_SIZE]: velocity to write.
- `nodes` out [1:0][NUM_NODES][POSITION_SIZE]: node positions.
- `velocities` out [1:0][NUM_NODES][VELOCITY_SIZE]: node velocities.
- `axle` out [1:0][POSITION_SIZE]: axle position.
- `axle_velocity` out [1:0][VELOCITY_SIZE]: axle velocity.
- `busy` out 1: high in ACCUM and INTEGRATE.
- `output_valid` out 1: one-cycle pulse when the step completes.
- `dropped_out` out 1: sticky flag; set when a force is discarded.

## Operation
- **States:** IDLE, ACCUM, INTEGRATE, DONE.
- **IDLE**
  - `load_valid` writes the selected entry.
  - `force_in_valid` accumulates at index 0 and moves to ACCUM.
  - `forces_done` alone moves to INTEGRATE with zero node forces.
- **ACCUM**
  - Each `force_in_valid` saturating-adds into `acc[idx]`, then `idx` increments.
  - `idx` wraps from NUM_NODES-1 to 0, so multiple force passes sum.
  - Accumulators are signed, FORCE_SIZE+4 bits wide.
  - On `forces_done`: capture the axle force, set `i`=0, go to INTEGRATE.
  - `force_in_valid` and `forces_done` in the same cycle: the force is accumulated first, then the transition occurs.
- **INTEGRATE:** processes one entry per cycle, `i` = 0..NUM_NODES; entry NUM_NODES is the axle and uses the captured axle force.
  - fx = acc_x, fy = sat(acc_y + gravity).
  - v' = satV(v + (f >>> DT_SHIFT)).
  - p' = satP(p + (v' >>> DT_SHIFT)).
  - `>>>` rounds toward −∞. All saturation clamps to the signed min/max of the target width.
- **DONE:** pulse `output_valid`, clear all accumulators and `idx`, return to IDLE.
- **Dropped inputs**
  - `force_in_valid` in INTEGRATE or DONE: the force is discarded and `dropped_out` is set.
  - `load_valid` outside IDLE is ignored.
- **Reset:** state IDLE; all positions, velocities, accumulators and counters cleared to 0; every output is 0. Reset aborts a step in progress.

## Timing
- `forces_done` sampled high in cycle t:
  - INTEGRATE occupies cycles t+1..t+NUM_NODES+1.
  - `output_valid` is high in cycle t+NUM_NODES+2.
  - IDLE is entered at t+NUM_NODES+3.
- Array outputs are registered and update entry-by-entry during INTEGRATE. Consumers sample them only on `output_valid`.
- A load in IDLE is visible on the outputs in the next cycle.
- `busy` is registered and reflects the current state.

## Structure
- Package `physics_pkg` holds:
  - state enum `integ_state_t`;
  - `ACC_EXTRA` = 4;
  - saturating-add functions, parameterised by width.
- Sub-module `euler_step`: combinational v'/p' computation for one axis. Instantiate it twice (x, y) and time-multiplex it across entries.

## Test plan
All scenarios use NUM_NODES=4, DT_SHIFT=2, gravity=−4.
- **Reset:** assert `rst_in` 2 cycles → all arrays 0, `output_valid`=0, `busy`=0, `dropped_out`=0.
- **Single step:**
  - Stimulus: load node 1 p=(10,20), v=(0,0); stream 4 forces of (8,0); then `forces_done` at t.
  - Response: node 1 v=(2,−1), p=(10,19); `output_valid` at t+6; node 0 v=(2,−1), p=(0,−1).
- **Saturation:** load node 0 v=(120,0); force (127,4) → v=(127,0), p=(31,0).
- **Same-cycle end:** third force (40,0) arrives with `forces_done` → node 2 vx=10; node 3 vx=0.
- **Dropped force:** `force_in_valid` during INTEGRATE → state unchanged, `dropped_out`=1 until reset.
- **Reset mid-INTEGRATE:** `rst_in` at t+3 → all arrays 0, no `output_valid` pulse; a subsequent frame behaves as in the single-step scenario.
